data_mem_responder: RTL

//  Data-memory responder for the pipelined MIPS core's M-stage port (MemRead_M/MemWrite_M/

---
 rtl/data_mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Purpose : word RAM behind the MIPS M-stage data port with a fixed multi-cycle access time.
// Latency : request seen in IDLE at cycle t commits at the end of t+LATENCY, MemDone pulses at t+LATENCY+1.
// Backpr. : MemStall holds the core (F..M frozen) from the request cycle through commit; inputs must stay stable.
//
// Ports
//   CLK          rising-edge clock
//   RST          asynchronous active-low reset
//   MemRead_M    load request
//   MemWrite_M   store request (wins over MemRead_M when both are set)
//   ALUResult_M  byte address, word index = ALUResult_M[ADDR_W+1:2], upper bits alias
//   WriteData_M  store data
//   ReadData_M   registered load data, holds last load value
//   MemStall     stall request to the hazard unit
//   MemDone      single-cycle completion pulse
//   AddrErr      sticky misaligned-access flag
module data_mem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MemRead_M,
   input  logic        MemWrite_M,
   input  logic [31:0] ALUResult_M,
   input  logic [31:0] WriteData_M,
   output logic [31:0] ReadData_M,
   output logic        MemStall,
   output logic        MemDone,
   output logic        AddrErr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int          DEPTH   = 2 ** ADDR_W;
   localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                stall;
   logic                commit;
   logic                req;
   logic                misaligned;
   logic                mem_we;
   logic [ADDR_W-1:0]   idx;
   logic [31:0]         mem [0:DEPTH-1];

   // Address bits above the RAM range are intentionally ignored (aliasing).
   logic unused_addr_bits;
   assign unused_addr_bits = ^ALUResult_M[31:ADDR_W+2];

   assign req        = MemRead_M | MemWrite_M;
   assign idx        = ALUResult_M[ADDR_W+1:2];
   assign misaligned = |ALUResult_M[1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      stall   = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            // Stall in the same cycle the request appears so the core never advances past it.
            stall = req;
            if (req) begin
               cnt_d   = LAT_CNT;
               state_d = BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               // Inputs are sampled here, at commit, not at request time.
               commit  = 1'b1;
               state_d = DONE;
               if (misaligned) begin
                  err_d = 1'b1;
               end
               if (MemRead_M && !MemWrite_M) begin
                  rdata_d = mem[idx];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Misaligned stores are dropped; a reset mid-access returns the FSM to IDLE so no write fires.
   assign mem_we = commit & MemWrite_M & ~misaligned;

   // RAM contents survive reset.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[idx] <= WriteData_M;
      end
   end

   // The IDLE stall is combinational from req, so it is masked while reset is held.
   assign MemStall   = stall & RST;
   assign MemDone    = (state_q == DONE);
   assign ReadData_M = rdata_q;
   assign AddrErr    = err_q;

endmodule
